frame_config_sequencer: RTL and testbench
=========================================

// Module: frame_config_sequencer
// PURPOSE
//  Streams the configuration bitstream into fabric tiles with frame-based config (CLB/DSP/term tiles).
//  Accepts 32-bit words over a valid/ready stream, decodes frame headers and collects NUM_ROWS data words.
//  Drives the row-wide frame_data bus and pulses one column/frame strobe per completed frame.
//  Sits between the config UART/bitbang front end and the fabric's FrameData/FrameStrobe distribution.
// PARAMETERS
//  NUM_ROWS        4   tile rows per column; one 32-bit word per row per frame
//  NUM_COLS        8   fabric columns addressable by a header
//  FRAMES_PER_COL  20  frames per column (strobe lines per column)
// PORTS
//  CLK           in   1                        fabric clock
//  resetn        in   1                        asynchronous active-low reset
//  s_data        in   32                       bitstream word
//  s_valid       in   1                        s_data valid
//  s_ready       out  1                        word accepted when s_valid & s_ready
//  frame_data    out  32*NUM_ROWS              row r at [32r+31:32r]
//  frame_strobe  out  NUM_COLS*FRAMES_PER_COL  one-hot, bit col*FRAMES_PER_COL+frame
//  busy          out  1                        high in every state except IDLE
//  done          out  1                        1-cycle pulse on END command
//  err           out  1                        sticky bad-address flag
//  frame_count   out  16                       frames strobed since last sync, saturating
// BEHAVIOUR
//  Reset: all outputs 0, except s_ready=1 (IDLE accepts words). State IDLE, buffers cleared.
//  Header word: [31:28] cmd (1=WRITE, F=END, other=NOP); [23:16] col; [7:0] frame.
//  IDLE:   accept and discard words until s_data==SYNC_WORD (32'hFAB0_FAB1).
//          On sync: -> HDR, clear err and frame_count.
//  HDR:    accept one word.
//          WRITE -> DATA, row index=0; address latched, bad if col>=NUM_COLS or frame>=FRAMES_PER_COL.
//          END -> IDLE; done pulses the following cycle.
//          NOP -> stay in HDR.
//  DATA:   accept NUM_ROWS words; word i goes to internal row buffer i.
//          A word equal to SYNC_WORD is plain data here.
//          After word NUM_ROWS-1 -> LOAD.
//  LOAD:   s_ready=0; frame_data <= row buffer.
//          Bad address: set err, no strobe, -> HDR.
//          Good address: -> STROBE.
//  STROBE: s_ready=0; exactly one frame_strobe bit high for one cycle.
//          frame_count++ (saturates at FFFF); -> HDR.
//  Latency: last data word accepted at cycle t -> frame_data valid t+1 -> strobe at t+2.
//           Next word can be accepted at t+3.
//  frame_data holds its value until the next LOAD, so data is stable one cycle before, during and after the strobe.
//  s_ready=1 in IDLE/HDR/DATA. s_valid low stalls any state with no side effects; gaps are unlimited.
//  The sequencer never auto-resyncs: after a bad header it still consumes NUM_ROWS data words.
//  Async reset mid-frame: strobe drops immediately, the partial frame is lost, state returns to IDLE.
//  The err flag survives END and is cleared only by the next SYNC_WORD or by reset.
// STRUCTURE
//  Package frame_cfg_pkg holds:
//   - SYNC_WORD
//   - CMD_WRITE/CMD_END
//   - header field bit positions
//   - state enum {IDLE,HDR,DATA,LOAD,STROBE}
//  Sub-module frame_row_buffer holds NUM_ROWS x 32 regs, a write index and a full flag.
//  The FSM, address check and strobe decode stay in the top module.
// TESTING
//  1. Reset, then words 0x12345678, FAB0FAB1 -> first word ignored, busy=1 after sync, err=0.
//  2. Sync, hdr 0x1_00_02_00_03 form (col2, frame3), rows A0..A3 ->
//     frame_data={A3,A2,A1,A0}; frame_strobe bit 43 for 1 cycle, 2 cycles after A3; frame_count=1.
//  3. Same frame with s_valid toggling every other cycle -> identical strobe, no extra or early strobe.
//  4. Header col=8 (NUM_COLS=8) plus 4 data words -> no strobe, err=1.
//     A following valid frame still strobes; err stays 1 until the next sync.
//  5. END header 0xF0000000 -> done pulses 1 cycle, busy=0.
//     A subsequent non-sync word is ignored.
//  6. Deassert resetn during DATA, row 2 -> strobe 0 and frame_data 0 at once.
//     After release, a full sync+frame works normally.

Source files
------------

// File: rtl/frame_cfg_pkg.sv
// ---------------------------------------------------------------------------
// frame_cfg_pkg
//  Shared constants and types for the frame configuration sequencer:
//  the bitstream sync word, header command codes, header field positions
//  and the sequencer state encoding.
// ---------------------------------------------------------------------------
package frame_cfg_pkg;

    // Marks the start of a bitstream when seen while idle
    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    // Header command codes; any other code is a no-op
    localparam logic [3:0] CMD_WRITE = 4'h1;
    localparam logic [3:0] CMD_END   = 4'hF;

    // Header word field positions
    localparam int HDR_CMD_MSB   = 31;
    localparam int HDR_CMD_LSB   = 28;
    localparam int HDR_COL_MSB   = 23;
    localparam int HDR_COL_LSB   = 16;
    localparam int HDR_FRAME_MSB = 7;
    localparam int HDR_FRAME_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        LOAD,
        STROBE
    } state_t;

endpackage

// File: rtl/frame_row_buffer.sv
// ---------------------------------------------------------------------------
// frame_row_buffer
//  Collects one frame worth of row words (one 32-bit word per tile row).
//  Words are written in order starting at row 0; the buffer reports when
//  the next write lands in the last row and when all rows are filled.
// Ports
//  CLK         in   fabric clock
//  resetn      in   asynchronous active-low reset
//  i_clear     in   restart collection at row 0 (contents kept)
//  i_wr_en     in   write i_wr_data into the current row
//  i_wr_data   in   32-bit row word
//  o_rows      out  all rows, row r at [32r+31:32r]
//  o_last_row  out  current write index is the last row
//  o_full      out  every row has been written since the last clear
// ---------------------------------------------------------------------------
module frame_row_buffer
    import frame_cfg_pkg::*;
#(
    parameter int NUM_ROWS = 4
) (
    input  logic                     CLK,
    input  logic                     resetn,
    input  logic                     i_clear,
    input  logic                     i_wr_en,
    input  logic [31:0]              i_wr_data,
    output logic [32*NUM_ROWS-1:0]   o_rows,
    output logic                     o_last_row,
    output logic                     o_full
);

    localparam int IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    logic [31:0]      r_rows [NUM_ROWS];
    logic [IDX_W-1:0] r_wr_idx;
    logic             r_full;

    assign o_last_row = (r_wr_idx == IDX_W'(NUM_ROWS - 1));
    assign o_full     = r_full;

    for (genvar g = 0; g < NUM_ROWS; g++) begin : g_rows
        assign o_rows[32*g +: 32] = r_rows[g];
    end

    // Writes past the last row are dropped so a stray word can never wrap
    // around and corrupt row 0 before the frame has been consumed.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                r_rows[i] <= '0;
            end
            r_wr_idx <= '0;
            r_full   <= 1'b0;
        end else if (i_clear) begin
            r_wr_idx <= '0;
            r_full   <= 1'b0;
        end else if (i_wr_en && !r_full) begin
            r_rows[r_wr_idx] <= i_wr_data;
            if (o_last_row) begin
                r_full <= 1'b1;
            end else begin
                r_wr_idx <= r_wr_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_config_sequencer.sv
// ---------------------------------------------------------------------------
// frame_config_sequencer
//  Streams a configuration bitstream into frame-configured fabric tiles.
//  Waits for the sync word, then decodes headers: a WRITE header is
//  followed by NUM_ROWS data words which are presented on frame_data and
//  committed with a single one-hot frame strobe; an END header returns to
//  idle with a done pulse.
// Ports
//  CLK           in   fabric clock
//  resetn        in   asynchronous active-low reset
//  s_data        in   bitstream word
//  s_valid       in   s_data valid
//  s_ready       out  word accepted when s_valid & s_ready
//  frame_data    out  row-wide frame data, row r at [32r+31:32r]
//  frame_strobe  out  one-hot, bit col*FRAMES_PER_COL+frame
//  busy          out  high whenever not idle
//  done          out  one-cycle pulse after an END header
//  err           out  sticky bad-address flag, cleared by sync
//  frame_count   out  saturating count of frames strobed since sync
// ---------------------------------------------------------------------------
module frame_config_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 8,
    parameter int FRAMES_PER_COL = 20
) (
    input  logic                               CLK,
    input  logic                               resetn,
    input  logic [31:0]                        s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic [32*NUM_ROWS-1:0]             frame_data,
    output logic [NUM_COLS*FRAMES_PER_COL-1:0] frame_strobe,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic [15:0]                        frame_count
);

    localparam int STROBE_W = NUM_COLS * FRAMES_PER_COL;

    state_t                  r_state;
    logic [32*NUM_ROWS-1:0]  r_frame_data;
    logic [STROBE_W-1:0]     r_frame_strobe;
    logic                    r_done;
    logic                    r_err;
    logic [15:0]             r_frame_count;
    logic [7:0]              r_col;
    logic [7:0]              r_frame;
    logic                    r_bad;

    logic                    w_accept;
    logic [3:0]              w_hdr_cmd;
    logic [7:0]              w_hdr_col;
    logic [7:0]              w_hdr_frame;
    logic                    w_is_write_hdr;
    logic                    w_buf_clear;
    logic                    w_buf_wr;
    logic [32*NUM_ROWS-1:0]  w_buf_rows;
    logic                    w_last_row;
    logic                    w_buf_full;
    logic [15:0]             w_strobe_idx;
    logic [STROBE_W-1:0]     w_strobe_vec;

    assign s_ready  = (r_state == IDLE) || (r_state == HDR) || (r_state == DATA);
    assign w_accept = s_valid && s_ready;

    assign w_hdr_cmd   = s_data[HDR_CMD_MSB:HDR_CMD_LSB];
    assign w_hdr_col   = s_data[HDR_COL_MSB:HDR_COL_LSB];
    assign w_hdr_frame = s_data[HDR_FRAME_MSB:HDR_FRAME_LSB];

    assign w_is_write_hdr = (r_state == HDR) && w_accept && (w_hdr_cmd == CMD_WRITE);
    assign w_buf_clear    = w_is_write_hdr;
    assign w_buf_wr       = (r_state == DATA) && w_accept;

    // Only good addresses ever reach STROBE, so the index is always in range
    assign w_strobe_idx = 16'(r_col) * 16'(FRAMES_PER_COL) + 16'(r_frame);
    assign w_strobe_vec = STROBE_W'(1) << w_strobe_idx;

    frame_row_buffer #(
        .NUM_ROWS   (NUM_ROWS)
    ) u_row_buffer (
        .CLK        (CLK),
        .resetn     (resetn),
        .i_clear    (w_buf_clear),
        .i_wr_en    (w_buf_wr),
        .i_wr_data  (s_data),
        .o_rows     (w_buf_rows),
        .o_last_row (w_last_row),
        .o_full     (w_buf_full)
    );

    // Main sequencer. done and frame_strobe default low each cycle so they
    // can only ever be single-cycle pulses. The strobe is registered from
    // the STROBE state, so it appears the cycle after frame_data has been
    // loaded, giving the fabric a full cycle of setup on the data.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state        <= IDLE;
            r_frame_data   <= '0;
            r_frame_strobe <= '0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_frame_count  <= '0;
            r_col          <= '0;
            r_frame        <= '0;
            r_bad          <= 1'b0;
        end else begin
            r_done         <= 1'b0;
            r_frame_strobe <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept && (s_data == SYNC_WORD)) begin
                        r_state       <= HDR;
                        r_err         <= 1'b0;
                        r_frame_count <= '0;
                    end
                end
                HDR: begin
                    if (w_accept) begin
                        if (w_hdr_cmd == CMD_WRITE) begin
                            r_state <= DATA;
                            r_col   <= w_hdr_col;
                            r_frame <= w_hdr_frame;
                            r_bad   <= (32'(w_hdr_col) >= NUM_COLS) ||
                                       (32'(w_hdr_frame) >= FRAMES_PER_COL);
                        end else if (w_hdr_cmd == CMD_END) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_accept && w_last_row) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_frame_data <= w_buf_rows;
                    if (r_bad) begin
                        r_err   <= 1'b1;
                        r_state <= HDR;
                    end else if (w_buf_full) begin
                        r_state <= STROBE;
                    end else begin
                        r_state <= HDR;
                    end
                end
                STROBE: begin
                    r_frame_strobe <= w_strobe_vec;
                    if (r_frame_count != 16'hFFFF) begin
                        r_frame_count <= r_frame_count + 16'd1;
                    end
                    r_state <= HDR;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign frame_data   = r_frame_data;
    assign frame_strobe = r_frame_strobe;
    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign err          = r_err;
    assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_config_sequencer
//  Directed bench for frame_config_sequencer. Each task drives one scenario
//  and compares outputs against hand-computed values at falling edges.
// ---------------------------------------------------------------------------
module tb_frame_config_sequencer;

    localparam int NUM_ROWS       = 4;
    localparam int NUM_COLS       = 8;
    localparam int FRAMES_PER_COL = 20;
    localparam int STROBE_W       = NUM_COLS * FRAMES_PER_COL;
    localparam logic [31:0] SYNC  = 32'hFAB0_FAB1;

    logic                      CLK = 1'b0;
    logic                      resetn;
    logic [31:0]               s_data;
    logic                      s_valid;
    logic                      s_ready;
    logic [32*NUM_ROWS-1:0]    frame_data;
    logic [STROBE_W-1:0]       frame_strobe;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic [15:0]               frame_count;

    int checks      = 0;
    int errors      = 0;
    int strobeCount = 0;

    frame_config_sequencer #(
        .NUM_ROWS       (NUM_ROWS),
        .NUM_COLS       (NUM_COLS),
        .FRAMES_PER_COL (FRAMES_PER_COL)
    ) dut (
        .CLK          (CLK),
        .resetn       (resetn),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .frame_data   (frame_data),
        .frame_strobe (frame_strobe),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .frame_count  (frame_count)
    );

    always #5 CLK = ~CLK;

    // Counts every cycle in which any strobe line is high
    always @(negedge CLK) begin
        if (frame_strobe != '0) strobeCount++;
    end

    // Global safety net in case a scenario stalls without hitting a bound
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Presents one word after an optional idle gap and holds it until accepted
    task automatic sendWord(input logic [31:0] w, input int gap);
        int n;
        repeat (gap) @(negedge CLK);
        @(negedge CLK);
        s_data  = w;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout word=%h s_ready=%b required 1", w, s_ready);
        end
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(negedge CLK);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready got %b want 1", s_ready); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_flags got busy=%b done=%b err=%b want 0 0 0", busy, done, err);
        end
        checks++;
        if (frame_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got %h want 0", frame_count); end
        checks++;
        if (frame_data !== '0 || frame_strobe !== '0) begin
            errors++; $display("[TB] FAIL reset_buses got data=%h strobe=%h want 0", frame_data, frame_strobe);
        end
        resetn = 1'b1;
        @(negedge CLK);
        sendWord(32'h1234_5678, 0);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL pre_sync_busy got %b want 0", busy); end
        sendWord(SYNC, 0);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL post_sync got busy=%b err=%b want 1 0", busy, err);
        end
    endtask

    task automatic test_frame();
        logic [STROBE_W-1:0]    expStrobe;
        logic [32*NUM_ROWS-1:0] expData;
        int base;
        expStrobe     = '0;
        expStrobe[43] = 1'b1;
        expData       = {32'hA333_3333, 32'hA222_2222, 32'hA111_1111, 32'hA000_0000};
        sendWord(32'h0000_0000, 0);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL nop_stays_hdr got busy=%b s_ready=%b want 1 1", busy, s_ready);
        end
        base = strobeCount;
        sendWord(32'h1002_0003, 0);
        sendWord(32'hA000_0000, 0);
        sendWord(32'hA111_1111, 0);
        sendWord(32'hA222_2222, 0);
        sendWord(32'hA333_3333, 0);
        @(negedge CLK);
        checks++;
        if (frame_strobe !== '0 || s_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL frame_load_cycle got strobe=%h s_ready=%b want 0 0", frame_strobe, s_ready);
        end
        @(negedge CLK);
        checks++;
        if (frame_data !== expData || frame_strobe !== '0) begin
            errors++; $display("[TB] FAIL frame_data_early got data=%h strobe=%h want %h 0", frame_data, frame_strobe, expData);
        end
        @(negedge CLK);
        checks++;
        if (frame_strobe !== expStrobe) begin
            errors++; $display("[TB] FAIL frame_strobe got %h want %h", frame_strobe, expStrobe);
        end
        checks++;
        if (frame_count !== 16'd1) begin errors++; $display("[TB] FAIL frame_count got %0d want 1", frame_count); end
        @(negedge CLK);
        checks++;
        if (frame_strobe !== '0 || frame_data !== expData || s_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL frame_after got strobe=%h data=%h s_ready=%b", frame_strobe, frame_data, s_ready);
        end
        checks++;
        if (strobeCount - base !== 1) begin
            errors++; $display("[TB] FAIL frame_pulses got %0d want 1", strobeCount - base);
        end
    endtask

    task automatic test_stall();
        logic [STROBE_W-1:0]    expStrobe;
        logic [32*NUM_ROWS-1:0] expData;
        int base;
        expStrobe     = '0;
        expStrobe[43] = 1'b1;
        expData       = {32'hB333_3333, SYNC, 32'hB111_1111, 32'hB000_0000};
        base = strobeCount;
        sendWord(32'h1002_0003, 1);
        sendWord(32'hB000_0000, 1);
        sendWord(32'hB111_1111, 1);
        checks++;
        if (strobeCount != base) begin errors++; $display("[TB] FAIL stall_early_strobe got %0d want 0", strobeCount - base); end
        sendWord(SYNC, 1);
        sendWord(32'hB333_3333, 1);
        @(negedge CLK);
        checks++;
        if (frame_strobe !== '0) begin errors++; $display("[TB] FAIL stall_load_cycle got %h want 0", frame_strobe); end
        @(negedge CLK);
        checks++;
        if (frame_data !== expData) begin errors++; $display("[TB] FAIL stall_data got %h want %h", frame_data, expData); end
        @(negedge CLK);
        checks++;
        if (frame_strobe !== expStrobe || frame_count !== 16'd2) begin
            errors++; $display("[TB] FAIL stall_strobe got %h count=%0d want %h 2", frame_strobe, frame_count, expStrobe);
        end
        @(negedge CLK);
        checks++;
        if (strobeCount - base !== 1) begin errors++; $display("[TB] FAIL stall_pulses got %0d want 1", strobeCount - base); end
    endtask

    task automatic test_bad_addr();
        logic [STROBE_W-1:0]    expStrobe;
        logic [32*NUM_ROWS-1:0] expData;
        int base;
        expStrobe      = '0;
        expStrobe[159] = 1'b1;
        expData        = {32'hD333_3333, 32'hD222_2222, 32'hD111_1111, 32'hD000_0000};
        base = strobeCount;
        sendWord(32'h1008_0000, 0);
        for (int i = 0; i < NUM_ROWS; i++) sendWord(32'hC000_0000 + i, 0);
        repeat (4) @(negedge CLK);
        checks++;
        if (strobeCount != base || err !== 1'b1) begin
            errors++; $display("[TB] FAIL bad_col got pulses=%0d err=%b want 0 1", strobeCount - base, err);
        end
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL bad_col_state got busy=%b s_ready=%b want 1 1", busy, s_ready);
        end
        sendWord(32'h1000_0014, 0);
        for (int i = 0; i < NUM_ROWS; i++) sendWord(32'hC100_0000 + i, 0);
        repeat (4) @(negedge CLK);
        checks++;
        if (strobeCount != base || frame_count !== 16'd2) begin
            errors++; $display("[TB] FAIL bad_frame got pulses=%0d count=%0d want 0 2", strobeCount - base, frame_count);
        end
        sendWord(32'h1007_0013, 0);
        sendWord(32'hD000_0000, 0);
        sendWord(32'hD111_1111, 0);
        sendWord(32'hD222_2222, 0);
        sendWord(32'hD333_3333, 0);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (frame_data !== expData) begin errors++; $display("[TB] FAIL edge_data got %h want %h", frame_data, expData); end
        @(negedge CLK);
        checks++;
        if (frame_strobe !== expStrobe || err !== 1'b1 || frame_count !== 16'd3) begin
            errors++; $display("[TB] FAIL edge_strobe got %h err=%b count=%0d want %h 1 3", frame_strobe, err, frame_count, expStrobe);
        end
    endtask

    task automatic test_end();
        sendWord(32'hF000_0000, 0);
        @(negedge CLK);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b1) begin
            errors++; $display("[TB] FAIL end_pulse got done=%b busy=%b err=%b want 1 0 1", done, busy, err);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL end_pulse_width got %b want 0", done); end
        sendWord(32'h1234_5678, 0);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL end_ignore got busy=%b done=%b want 0 0", busy, done);
        end
        sendWord(SYNC, 0);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || frame_count !== 16'd0) begin
            errors++; $display("[TB] FAIL resync got busy=%b err=%b count=%0d want 1 0 0", busy, err, frame_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [STROBE_W-1:0]    expStrobe;
        logic [32*NUM_ROWS-1:0] expData;
        expStrobe    = '0;
        expStrobe[0] = 1'b1;
        expData      = {32'hF333_3333, 32'hF222_2222, 32'hF111_1111, 32'hF000_0000};
        sendWord(32'h1000_0000, 0);
        sendWord(32'hE000_0000, 0);
        sendWord(32'hE111_1111, 0);
        @(negedge CLK);
        resetn = 1'b0;
        #1;
        checks++;
        if (frame_data !== '0 || frame_strobe !== '0) begin
            errors++; $display("[TB] FAIL async_reset_buses got data=%h strobe=%h want 0", frame_data, frame_strobe);
        end
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL async_reset_state got busy=%b s_ready=%b want 0 1", busy, s_ready);
        end
        @(negedge CLK);
        resetn = 1'b1;
        sendWord(SYNC, 0);
        sendWord(32'h1000_0000, 0);
        sendWord(32'hF000_0000, 0);
        sendWord(32'hF111_1111, 0);
        sendWord(32'hF222_2222, 0);
        sendWord(32'hF333_3333, 0);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (frame_data !== expData) begin errors++; $display("[TB] FAIL post_reset_data got %h want %h", frame_data, expData); end
        @(negedge CLK);
        checks++;
        if (frame_strobe !== expStrobe || frame_count !== 16'd1) begin
            errors++; $display("[TB] FAIL post_reset_strobe got %h count=%0d want %h 1", frame_strobe, frame_count, expStrobe);
        end
    endtask

    initial begin
        $display("[TB] starting frame_config_sequencer bench");
        test_reset();
        test_frame();
        test_stall();
        test_bad_addr();
        test_end();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
